// File: rtl/l4_mac_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : helper (package)
// Description : Shared types and constants for the L4 MAC job scheduler.
//               sched_state_e   - scheduler FSM states.
//               SCHED_RES_DEPTH - entries in the result buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package helper;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } sched_state_e;

    localparam int SCHED_RES_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/l4_mac_sched_res_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sched_res_fifo
// Description : Small shift-register FIFO for scheduler results. The head
//               entry is always slot 0, so pop_data comes straight from a
//               register.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               push, push_data  - write one entry (ignored when full)
//               pop              - discard head entry (ignored when empty)
//               pop_data         - head entry (registered)
//               full, empty      - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module sched_res_fifo
    import helper::*;
#(
    parameter int DEPTH = SCHED_RES_DEPTH,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [DEPTH-1:0][WIDTH-1:0] w_up;
    logic [c_CNT_W-1:0]          r_cnt;
    logic [c_CNT_W-1:0]          w_wr_idx;
    logic                        w_push;
    logic                        w_pop;

    assign empty    = (r_cnt == '0);
    assign full     = (r_cnt == c_CNT_W'(DEPTH));
    assign w_pop    = pop && !empty;
    assign w_push   = push && !full;
    // A simultaneous pop shifts everything down, so the new entry lands one
    // slot lower than the current fill level.
    assign w_wr_idx = r_cnt - c_CNT_W'(w_pop);
    assign w_up     = r_mem >> WIDTH;
    assign pop_data = r_mem[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem <= '0;
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (w_wr_idx == c_CNT_W'(i))) begin
                    r_mem[i] <= push_data;
                end else if (w_pop) begin
                    r_mem[i] <= w_up[i];
                end
            end
            r_cnt <= r_cnt + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/l4_mac_sched.sv
`default_nettype none
// ============================================================================
// Module      : l4_mac_sched
// Description : Job scheduler for the registered L4 MAC wrapper. Accepts job
//               descriptors, gates operand beats into the MAC, restarts
//               accumulation on each job's first beat, captures z when the
//               last beat has been accumulated and returns results through
//               a 2-entry valid/ready buffer.
// Ports       : cfg_valid/cfg_ready/cfg_prec/cfg_len - job descriptor
//               op_valid/op_ready                    - operand beat handshake
//               mac_op_zero/mac_accum_en/mac_prec    - MAC control
//               z                                    - MAC result
//               res_valid/res_ready/res_data         - result stream
//               busy                                 - issuing or capture pending
//               stat_beats/stat_stalls               - only with L4_SCHED_STATS_EN
// Config      : `define L4_SCHED_STATS_EN adds saturating beat/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module l4_mac_sched
    import helper::*;
#(
    parameter int LEN_W    = 16,
    parameter int Z_WIDTH  = 32,
    parameter int PIPE_LAT = 2,
    parameter int PREC_DLY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [3:0]         cfg_prec,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               op_valid,
    output logic               op_ready,
    output logic               mac_op_zero,
    output logic               mac_accum_en,
    output logic [3:0]         mac_prec,
    input  logic [Z_WIDTH-1:0] z,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [Z_WIDTH-1:0] res_data,
    output logic               busy
`ifdef L4_SCHED_STATS_EN
    ,
    output logic [31:0]        stat_beats,
    output logic [31:0]        stat_stalls
`endif
);

    sched_state_e        r_state;
    sched_state_e        w_state_nxt;
    logic [1:0]          r_credits;
    logic [LEN_W-1:0]    r_beat_cnt;
    logic [3:0]          r_job_prec;
    logic                r_first;
    logic [PIPE_LAT-1:0] r_tok;
    logic [3:0]          r_mac_prec;
    logic                w_accept;
    logic                w_issue;
    logic                w_first_issue;
    logic                w_issue_last;
    logic                w_capture;
    logic                w_pop;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_prec_load;
    logic [3:0]          w_prec_val;

    assign w_accept      = cfg_valid && cfg_ready;
    assign w_issue       = (r_state == S_RUN) && op_valid;
    assign w_first_issue = w_issue && r_first;
    assign w_issue_last  = w_issue && (r_beat_cnt == '0);
    assign w_capture     = r_tok[PIPE_LAT-1];
    assign w_pop         = res_valid && res_ready;

    // ------------------------------------------------------------------
    // FSM: next state and MAC control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        cfg_ready    = 1'b0;
        op_ready     = 1'b0;
        mac_op_zero  = 1'b1;
        mac_accum_en = 1'b1;
        case (r_state)
            S_IDLE: begin
                cfg_ready = (r_credits < 2'd2);
                if (cfg_valid && (r_credits < 2'd2)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                op_ready = 1'b1;
                // Stall cycles feed zero with accumulate on, so the
                // accumulator simply holds.
                if (op_valid) begin
                    mac_op_zero  = 1'b0;
                    mac_accum_en = !r_first;
                    if (r_beat_cnt == '0) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_credits  <= 2'd0;
            r_beat_cnt <= '0;
            r_job_prec <= 4'd0;
            r_first    <= 1'b0;
            r_tok      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_beat_cnt <= cfg_len;
                r_job_prec <= cfg_prec;
                r_first    <= 1'b1;
            end else if (w_issue) begin
                r_beat_cnt <= r_beat_cnt - LEN_W'(1);
                r_first    <= 1'b0;
            end
            // Last-beat token travels the MAC latency before capture.
            r_tok <= PIPE_LAT'({r_tok, w_issue_last});
            case ({w_accept, w_pop})
                2'b10:   r_credits <= r_credits + 2'd1;
                2'b01:   r_credits <= r_credits - 2'd1;
                default: r_credits <= r_credits;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Precision switch, delayed from the job's first beat. The precision
    // travels with the delay so a following descriptor cannot overwrite it.
    // ------------------------------------------------------------------
    if (PREC_DLY <= 1) begin : g_prec_direct
        assign w_prec_load = w_first_issue;
        assign w_prec_val  = r_job_prec;
    end else begin : g_prec_pipe
        localparam int c_PD = PREC_DLY - 1;
        logic [c_PD-1:0]      r_pv;
        logic [c_PD-1:0][3:0] r_pp;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_pv <= '0;
                r_pp <= '0;
            end else begin
                for (int i = c_PD - 1; i > 0; i--) begin
                    r_pv[i] <= r_pv[i-1];
                    r_pp[i] <= r_pp[i-1];
                end
                r_pv[0] <= w_first_issue;
                r_pp[0] <= r_job_prec;
            end
        end

        assign w_prec_load = r_pv[c_PD-1];
        assign w_prec_val  = r_pp[c_PD-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mac_prec <= 4'd0;
        end else if (w_prec_load) begin
            r_mac_prec <= w_prec_val;
        end
    end

    assign mac_prec = r_mac_prec;
    assign busy     = (r_state == S_RUN) || (|r_tok);
    assign res_valid = !w_fifo_empty;

    // ------------------------------------------------------------------
    // Result buffer
    // ------------------------------------------------------------------
    sched_res_fifo #(
        .DEPTH (SCHED_RES_DEPTH),
        .WIDTH (Z_WIDTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_capture),
        .push_data (z),
        .pop       (w_pop),
        .pop_data  (res_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // Credits bound outstanding jobs to the buffer depth, so a capture
    // into a full buffer means the credit logic is broken.
    always_ff @(posedge clk) begin
        if (!rst && w_capture) begin
            assert (!w_fifo_full);
        end
    end

`ifdef L4_SCHED_STATS_EN
    logic [31:0] r_stat_beats;
    logic [31:0] r_stat_stalls;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_beats  <= '0;
            r_stat_stalls <= '0;
        end else begin
            if (w_issue && (r_stat_beats != '1)) begin
                r_stat_beats <= r_stat_beats + 32'd1;
            end
            if ((r_state == S_RUN) && !op_valid && (r_stat_stalls != '1)) begin
                r_stat_stalls <= r_stat_stalls + 32'd1;
            end
        end
    end

    assign stat_beats  = r_stat_beats;
    assign stat_stalls = r_stat_stalls;
`endif

endmodule
`default_nettype wire

// File: doc/l4_mac_sched.md
# l4_mac_sched

Job scheduler for the registered L4 MAC wrapper.
- Accepts job descriptors (precision, reduction length) and gates the operand stream into the MAC.
- Drives the MAC's `accum_en` and `prec` so each job's first beat restarts accumulation.
- Captures `z` exactly when the job's last beat has been accumulated, and returns results through a 2-entry valid/ready result buffer.
- Sits between the operand/descriptor sources and the L4 MAC top; it owns all MAC control pins.

## Interface
Parameters:
- `LEN_W`, 16: width of the job length field.
- `Z_WIDTH`, 32: width of the MAC result `z`; must match the instantiated MAC.
- `PIPE_LAT`, 2: cycles from a beat issued on the MAC inputs to `z` reflecting it (input register + accumulator).
- `PREC_DLY`, 1: cycles from issuing the first beat of a job to `mac_prec` switching to that job's precision.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `cfg_valid`, in, 1: job descriptor valid.
- `cfg_ready`, out, 1: descriptor accepted when `cfg_valid && cfg_ready`.
- `cfg_prec`, in, 4: job precision; encoding identical to MAC `prec`.
- `cfg_len`, in, LEN_W: number of beats minus one (0 = 1 beat).
- `op_valid`, in, 1: upstream operands valid this cycle.
- `op_ready`, out, 1: operand beat consumed when `op_valid && op_ready`.
- `mac_op_zero`, out, 1: top forces a/w to zero this cycle (bubble).
- `mac_accum_en`, out, 1: to MAC `accum_en`; 0 restarts accumulation.
- `mac_prec`, out, 4: to MAC `prec`.
- `z`, in, Z_WIDTH: MAC result.
- `res_valid`, out, 1: result available.
- `res_ready`, in, 1: result consumer ready.
- `res_data`, out, Z_WIDTH: result.
- `busy`, out, 1: a job is issuing or a capture is in flight.

## Operation
- FSM `S_IDLE`, `S_RUN`.
- `S_IDLE`:
  - `cfg_ready` = credits < 2. Credits = jobs accepted whose result has not yet been popped from the result buffer.
  - On accept: latch prec and len into `beat_cnt`, credits+1, go to `S_RUN`.
  - `op_ready`=0, `mac_op_zero`=1, `mac_accum_en`=1.
- `S_RUN`:
  - `op_ready`=1.
  - Each cycle with `op_valid`=1 issues a beat: `mac_op_zero`=0; `mac_accum_en`=0 on the job's first beat, else 1. `beat_cnt` decrements.
  - Cycle with `op_valid`=0: `mac_op_zero`=1, `mac_accum_en`=1. This stalls with zero contribution; the accumulator keeps its value.
  - Issuing the beat with `beat_cnt`==0 pushes a `last` token into a PIPE_LAT-deep delay line and returns to `S_IDLE`.
- Capture: when the token exits the delay line, `z` is written into the result buffer.
  - Credit gating guarantees the buffer is never full at capture time; an overflow is a design error and is asserted in simulation.
- Result pop: `res_valid && res_ready` pops the buffer and decrements credits. Same-cycle accept and pop leaves credits unchanged.
- `mac_prec`: updates to the new job's prec exactly PREC_DLY cycles after that job's first beat issues; otherwise it holds. Previous-job beats still in flight therefore see the old prec.
- `busy` = (state==`S_RUN`) or any token in the delay line.

## Timing
- Reset values:
  - state `S_IDLE`, credits 0, delay line cleared, buffer empty.
  - `cfg_ready`=1, `op_ready`=0, `mac_op_zero`=1, `mac_accum_en`=1, `mac_prec`=0, `res_valid`=0, `res_data`=0, `busy`=0.
- Descriptor accept to first possible beat: 1 cycle.
- Last beat issued at cycle t: capture at t+PIPE_LAT, `res_valid`=1 at t+PIPE_LAT+1.
- Between jobs there is at least one `S_IDLE` bubble cycle, with `mac_accum_en`=1 and operands zeroed.
- Buffer full (credits==2): `cfg_ready`=0 until a pop.
- Reset mid-job: the job and any in-flight results are dropped, with no capture. The MAC is reset in parallel by the system.

## Configuration
- `L4_SCHED_STATS_EN` defined:
  - Adds outputs `stat_beats` [31:0] (issued beats) and `stat_stalls` [31:0] (`S_RUN` cycles with `op_valid`=0).
  - Both saturate at all-ones and clear on `rst`.
- `L4_SCHED_STATS_EN` undefined: the ports and counters are absent.

## Structure
- Add to package `helper`:
  - enum `sched_state_e` {`S_IDLE`, `S_RUN`}.
  - localparam `SCHED_RES_DEPTH` = 2.
- Sub-module `sched_res_fifo`: SCHED_RES_DEPTH-entry, Z_WIDTH-wide, registered-output FIFO with push/pop/full/empty. It holds the result buffer.

## Test plan
- Job prec=4'b0000, len=3, op_valid constant 1, a·w=5 per beat:
  - `mac_accum_en` pattern 0,1,1,1.
  - `res_data`=20, `res_valid` 3 cycles after the last beat.
- Same job with `op_valid` low for 2 cycles mid-job: result still 20, `stat_stalls`=2.
- Three jobs queued with `res_ready`=0:
  - Third descriptor held (`cfg_ready`=0) after two accepts.
  - Raise `res_ready`: third accepted the cycle after the first pop.
- Back-to-back jobs with prec 4'b0000 then 4'b1111, len=0 each: `mac_prec` switches PREC_DLY cycles after the second job's beat; both results are correct.
- `rst` asserted in `S_RUN` with 1 token in flight:
  - Next cycle all reset values hold.
  - No `res_valid` appears afterwards.
- len=0 with `op_valid`=1: single beat with `mac_accum_en`=0; returns to `S_IDLE` the next cycle.
